// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 8-digit common-anode hex display driver with frame-synchronous value commit.
// Optional build macro SEVEN_SEG_LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
module seven_seg_scan_driver #(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] value_in,
  input  logic        value_valid,
  output logic [6:0]  seg,
  output logic [7:0]  anode,
  output logic        frame_tick,
  output logic        update_pending
);

  localparam int DIGITS = 8;
  localparam int PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef logic [PW-1:0] presc_t;

  localparam presc_t     PRESC_LAST = presc_t'(PRESCALE - 1);
  localparam presc_t     BLANK_END  = presc_t'(BLANK_CYCLES);
  localparam logic [2:0] IDX_LAST   = 3'(DIGITS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // Bit i set when digit i is at or below the most significant nonzero nibble; digit 0 always shown.
  function automatic logic [7:0] lead_mask(input logic [31:0] v);
    logic [7:0] m;
    logic       seen;
    m    = 8'h01;
    seen = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      if (v[4*i +: 4] != 4'h0) begin
        seen = 1'b1;
      end else begin
        seen = seen;
      end
      m[i] = seen;
    end
    return m;
  endfunction
`endif

  presc_t      presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] disp_q, disp_d;
  logic        pend_q, pend_d;
  logic [7:0]  mask_q, mask_d;
  logic [6:0]  seg_q, seg_d;
  logic [7:0]  anode_q, anode_d;
  logic        ftick_q, ftick_d;

  logic        presc_wrap_s;
  logic        frame_end_s;
  logic        commit_s;
  logic        lit_s;
  logic [3:0]  nibble_s;

  // Scan counters, capture/commit path and next-cycle output decode.
  always_comb begin
    presc_wrap_s = (presc_q == PRESC_LAST);
    frame_end_s  = presc_wrap_s && (idx_q == IDX_LAST);
    commit_s     = frame_end_s && (value_valid || pend_q);

    presc_d = presc_wrap_s ? {PW{1'b0}} : presc_q + presc_t'(1);
    idx_d   = presc_wrap_s ? idx_q + 3'd1 : idx_q;

    shadow_d = shadow_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    if (value_valid) begin
      shadow_d = value_in;
      if (frame_end_s) begin
        disp_d = value_in;
        pend_d = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (frame_end_s && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (commit_s) begin
      mask_d = lead_mask(disp_d);
    end else begin
      mask_d = mask_q;
    end
`else
    mask_d = 8'hFF;
`endif

    // Outputs are registered, so decode from the state the registers are about to hold.
    nibble_s = disp_d[{idx_d, 2'b00} +: 4];
    lit_s    = (presc_d >= BLANK_END) && mask_d[idx_d];
    if (lit_s) begin
      anode_d = ~(8'h01 << idx_d);
      seg_d   = hex7(nibble_s);
    end else begin
      anode_d = 8'hFF;
      seg_d   = 7'h7F;
    end
    ftick_d = frame_end_s;
  end

  // State and output registers; reset blanks the display asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q  <= {PW{1'b0}};
      idx_q    <= 3'd0;
      shadow_q <= 32'h0000_0000;
      disp_q   <= 32'h0000_0000;
      pend_q   <= 1'b0;
      mask_q   <= 8'h01;
      seg_q    <= 7'h7F;
      anode_q  <= 8'hFF;
      ftick_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      seg_q    <= seg_d;
      anode_q  <= anode_d;
      ftick_q  <= ftick_d;
    end
  end

  assign seg            = seg_q;
  assign anode          = anode_q;
  assign frame_tick     = ftick_q;
  assign update_pending = pend_q;

endmodule
